// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/capture front end: FSM state encoding,
// default widths, opcode constants and the wide-op test helper.
package alu_pkg;

    // Default operand/result and opcode widths
    localparam int DEF_DATA_W = 16;
    localparam int DEF_OP_W   = 4;

    // Settle counter width; covers SETTLE_CYC up to 15
    localparam int CNT_W = 4;

    // Opcode bit that marks ops producing a meaningful upper half
    localparam int WIDE_BIT = 3;

    // Opcode constants
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;

    // Front-end sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // True when the opcode writes the HI register as well as LO
    function automatic logic wide_op(input logic [WIDE_BIT:0] op);
        return op[WIDE_BIT];
    endfunction

endpackage

// File: rtl/alu_hilo_regs.sv
// HI/LO result registers plus the optional sticky overflow flag.
// Optional feature: ALU_STICKY_OVF_EN adds the sticky overflow register.
module alu_hilo_regs #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lo_we,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] upper,
    input  logic [DATA_W-1:0] lower,
`ifdef ALU_STICKY_OVF_EN
    input  logic              ovf_set,
    input  logic              ovf_clr,
    output logic              ovf_sticky,
`endif
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);

    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    // LO follows every capture; HI only on wide ops
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (lo_we) begin
                lo_reg <= lower;
            end
            if (hi_we) begin
                hi_reg <= upper;
            end
        end
    end

    assign hi_q = hi_reg;
    assign lo_q = lo_reg;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_reg;

    // Sticky overflow: a capture with overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (ovf_set) begin
            sticky_reg <= 1'b1;
        end else if (ovf_clr) begin
            sticky_reg <= 1'b0;
        end
    end

    assign ovf_sticky = sticky_reg;
`endif

endmodule

// File: rtl/alu_issue_capture.sv
// ALU issue/capture front end: accepts a request, holds the ALU operands in
// registers, waits SETTLE_CYC cycles, captures results into HI/LO and status
// registers and returns a response over a valid/ready handshake.
// Optional feature: ALU_STICKY_OVF_EN adds ovf_clr / ovf_sticky.
module alu_issue_capture
    import alu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OP_W       = DEF_OP_W,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_dat1,
    output logic [DATA_W-1:0] alu_dat2,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_upper,
    input  logic [DATA_W-1:0] alu_lower,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_lower,
    output logic              rsp_zero,
    output logic              rsp_ovf,
`ifdef ALU_STICKY_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf_sticky,
`endif
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);

    // Counter preload: the capture edge is SETTLE_CYC edges after accept
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;

    logic [DATA_W-1:0] dat1_reg;
    logic [DATA_W-1:0] dat2_reg;
    logic [OP_W-1:0]   op_reg;

    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_lower_reg;
    logic              rsp_zero_reg;
    logic              rsp_ovf_reg;

    logic              accept;
    logic              capture;
    logic              rsp_done;
    logic              hi_we;

    // Ready only while idle and not being reset
    assign req_ready = (state_reg == IDLE) && !rst;

    // Next-state and control strobes
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end else begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and settle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ALU operand registers change only on accept so the ALU sees stable inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dat1_reg <= '0;
            dat2_reg <= '0;
            op_reg   <= '0;
        end else if (accept) begin
            dat1_reg <= req_a;
            dat2_reg <= req_b;
            op_reg   <= req_op;
        end
    end

    // Response registers: loaded at capture, held until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_lower_reg <= '0;
            rsp_zero_reg  <= 1'b0;
            rsp_ovf_reg   <= 1'b0;
        end else if (capture) begin
            rsp_valid_reg <= 1'b1;
            rsp_lower_reg <= alu_lower;
            rsp_zero_reg  <= alu_zero;
            rsp_ovf_reg   <= alu_ovf;
        end else if (rsp_done) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign hi_we = capture && wide_op(op_reg[WIDE_BIT:0]);

    alu_hilo_regs #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk        (clk),
        .rst        (rst),
        .lo_we      (capture),
        .hi_we      (hi_we),
        .upper      (alu_upper),
        .lower      (alu_lower),
`ifdef ALU_STICKY_OVF_EN
        .ovf_set    (capture && alu_ovf),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
`endif
        .hi_q       (hi_q),
        .lo_q       (lo_q)
    );

    assign alu_dat1  = dat1_reg;
    assign alu_dat2  = dat2_reg;
    assign alu_op    = op_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_lower = rsp_lower_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign rsp_ovf   = rsp_ovf_reg;

endmodule
